imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the ID stage of the RISC-V pipeline; successor to the combinational immediate decoder.
- Supports XLEN 32/64, U-type (lui/auipc), RV64 OP-IMM-32, and illegal-encoding detection.
- Registered output with a valid/ready handshake, 1 or 2 internal stages, and a flush input for branch redirect.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- STAGES, 1, pipeline depth; legal values are 1 and 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instr is valid.
- in_ready  out  1  block accepts instr this cycle.
- instr  in  32  raw instruction word.
- flush  in  1  synchronous; kill all in-flight entries.
- out_valid  out  1  imm/fmt/illegal are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- imm  out  XLEN  sign- or zero-extended immediate.
- imm_fmt  out  3  format code; see package.
- imm_illegal  out  1  malformed immediate-carrying encoding.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - every stage valid bit = 0, so out_valid = 0;
  - imm = 0, imm_fmt = FMT_NONE, imm_illegal = 0;
  - reset asserted mid-operation discards all entries immediately.
- Handshake:
  - transfer on the input side when in_valid & in_ready; on the output side when out_valid & out_ready;
  - each stage k advances when !valid_k | ready_(k+1); ready of the final stage = out_ready;
  - in_ready = ready of stage 0, so accept and drain in the same cycle is allowed at full throughput;
  - while out_valid & !out_ready, imm/imm_fmt/imm_illegal are held stable.
- Latency: an accepted instr appears on out_valid exactly STAGES cycles later when there is no backpressure.
- STAGES = 2 split:
  - stage 1 registers instr and the classified format;
  - stage 2 registers the assembled immediate.
- Classification uses opcode = instr[6:0] and funct3 = instr[14:12]:
  - 0000011 load: FMT_I, imm = sext(instr[31:20]).
  - 0010011 OP-IMM, funct3 not 001/101: FMT_I, imm = sext(instr[31:20]).
  - 0010011 OP-IMM, funct3 001/101 (shifts): FMT_SHAMT.
    - XLEN = 32: imm = zext(instr[24:20]); illegal if instr[25] = 1.
    - XLEN = 64: imm = zext(instr[25:20]).
    - Also illegal if instr[31:26] is not 000000, or 010000 only when funct3 = 101.
  - 0011011 OP-IMM-32, XLEN = 64 only:
    - addiw: FMT_I;
    - shifts: FMT_SHAMT with a 5-bit shamt; illegal if instr[25] = 1;
    - XLEN = 32: treated as an unknown opcode.
  - 0100011 store: FMT_S, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 branch: FMT_B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
    - illegal if funct3 = 010 or 011.
  - 1100111 jalr: FMT_I; illegal if funct3 != 000.
  - 1101111 jal: FMT_J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110111 lui / 0010111 auipc: FMT_U, imm = sext({instr[31:12], 12'b0}) to XLEN.
  - 0110011 OP, 0111011 OP-32, 1110011 SYSTEM, 0001111 FENCE: FMT_NONE, imm = 0, illegal = 0.
  - any other opcode, including instr[1:0] != 11: FMT_NONE, imm = 0, illegal = 1.
- Sign extension replicates instr[31] up to XLEN for every sign-extended format.
- Flush:
  - on the next edge all valid bits are cleared; data registers are don't-care;
  - an instr accepted in the flush cycle is also dropped;
  - flush has priority over accept and hold.
- Simultaneous out_ready and in_valid with a full pipe: one in, one out, no bubble.

Decomposition:
- Package imm_pkg holds:
  - opcode constants (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP32, OPC_SYSTEM, OPC_FENCE);
  - format codes FMT_NONE = 0, FMT_I = 1, FMT_S = 2, FMT_B = 3, FMT_U = 4, FMT_J = 5, FMT_SHAMT = 6.
- One sub-module, imm_classify: purely combinational, instr -> {fmt, illegal}.
  - It is instantiated ahead of stage 1.
  - Immediate assembly lives in the top level, in stage 1 or stage 2 depending on STAGES.

Test Plan:
- Basic I-type: XLEN = 32, STAGES = 1; 0xFFF00093 (addi -1) -> after 1 cycle out_valid = 1, imm = 0xFFFFFFFF, fmt = FMT_I, illegal = 0.
- U-type sign extension: XLEN = 64; 0x12345037 -> imm = 0x0000000012345000; 0x80000037 -> imm = 0xFFFFFFFF80000000, fmt = FMT_U.
- Branch: 0xFE000EE3 (beq x0,x0,-4) -> imm = 0xFFFFFFFC, fmt = FMT_B; with STAGES = 2, output appears 2 cycles after accept.
- Shift bounds: 0x02009093 (slli x1,x1,32):
  - XLEN = 32 -> illegal = 1;
  - XLEN = 64 -> imm = 0x20, illegal = 0;
  - 0x0000000B (opcode 0001011) -> FMT_NONE, illegal = 1.
- Backpressure: STAGES = 2; stream 4 instrs while out_ready = 0 for 3 cycles.
  - in_ready drops once both stages are full;
  - outputs are held stable;
  - all 4 outputs emerge in order with no loss or duplication.
- Flush and reset:
  - flush with 2 entries in flight plus in_valid -> next cycle out_valid = 0 and none of those 3 entries ever appear;
  - async reset asserted mid-stream -> out_valid = 0, imm = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - opcode constants and immediate format codes for the ID-stage immediate generator
package imm_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  // Upper shift bits may only be zero, or 010000 for the arithmetic right shift.
  function automatic logic shamt_hi_ok(input logic [5:0] hi, input logic [2:0] funct3);
    return (hi == 6'b000000) || ((hi == 6'b010000) && (funct3 == 3'b101));
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  import imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  imm_fmt_e        imm_fmt;
  logic            imm_illegal;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, imm, imm_fmt, imm_illegal
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, imm, imm_fmt, imm_illegal
  );

endinterface

// File: rtl/imm_classify.sv
// rtl/imm_classify.sv - combinational instruction -> immediate format / illegal-encoding classifier
module imm_classify
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr,
  output imm_fmt_e    fmt,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] funct3;
  logic       is_shift;
  logic       hi_bad;
  logic       unused_bits;

  assign opc         = instr[6:0];
  assign funct3      = instr[14:12];
  assign is_shift    = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign hi_bad      = !shamt_hi_ok(instr[31:26], funct3);
  assign unused_bits = &{1'b0, instr[24:15], instr[11:7]};

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD: fmt = FMT_I;
      OPC_OPIMM: begin
        if (is_shift) begin
          fmt     = FMT_SHAMT;
          illegal = hi_bad || ((XLEN == 32) && instr[25]);
        end else begin
          fmt = FMT_I;
        end
      end
      // Word ops only exist on RV64; on RV32 they fall through as unknown.
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            fmt     = FMT_SHAMT;
            illegal = hi_bad || instr[25];
          end else begin
            fmt     = FMT_I;
            illegal = (funct3 != 3'b000);
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: fmt = FMT_S;
      OPC_BRANCH: begin
        fmt     = FMT_B;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JALR: begin
        fmt     = FMT_I;
        illegal = (funct3 != 3'b000);
      end
      OPC_JAL:              fmt = FMT_J;
      OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
      OPC_OP, OPC_OP32, OPC_SYSTEM, OPC_FENCE: fmt = FMT_NONE;
      default:              illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator (1 or 2 stages) with valid/ready and flush
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input logic         clk,
  input logic         reset,
  imm_gen_pipe_if.slave bus
);

  imm_fmt_e cls_fmt;
  logic     cls_ill;

  imm_classify #(.XLEN(XLEN)) u_classify (
    .instr   (bus.instr),
    .fmt     (cls_fmt),
    .illegal (cls_ill)
  );

  // Every format is built as a 32-bit value whose bit 31 is the extension bit.
  function automatic logic [XLEN-1:0] build_imm(input logic [31:0] i, input imm_fmt_e f);
    logic [31:0] v;
    case (f)
      FMT_I:     v = {{20{i[31]}}, i[31:20]};
      FMT_S:     v = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:     v = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:     v = {i[31:12], 12'b0};
      FMT_J:     v = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      FMT_SHAMT: v = ((XLEN == 64) && (i[6:0] == OPC_OPIMM)) ? {26'b0, i[25:20]}
                                                             : {27'b0, i[24:20]};
      default:   v = '0;
    endcase
    return XLEN'($signed(v));
  endfunction

  if (STAGES == 1) begin : g_one
    logic            v1;
    logic            rdy1;
    logic [XLEN-1:0] imm1;
    imm_fmt_e        fmt1;
    logic            ill1;

    assign rdy1 = !v1 || bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v1   <= 1'b0;
        imm1 <= '0;
        fmt1 <= FMT_NONE;
        ill1 <= 1'b0;
      end else if (bus.flush) begin
        v1 <= 1'b0;
      end else if (rdy1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          imm1 <= build_imm(bus.instr, cls_fmt);
          fmt1 <= cls_fmt;
          ill1 <= cls_ill;
        end
      end
    end

    assign bus.in_ready    = rdy1;
    assign bus.out_valid   = v1;
    assign bus.imm         = imm1;
    assign bus.imm_fmt     = fmt1;
    assign bus.imm_illegal = ill1;
  end else begin : g_two
    logic            v1;
    logic            v2;
    logic            rdy1;
    logic            rdy2;
    logic [31:0]     instr1;
    imm_fmt_e        fmt1;
    logic            ill1;
    logic [XLEN-1:0] imm2;
    imm_fmt_e        fmt2;
    logic            ill2;

    assign rdy2 = !v2 || bus.out_ready;
    assign rdy1 = !v1 || rdy2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v1     <= 1'b0;
        v2     <= 1'b0;
        instr1 <= '0;
        fmt1   <= FMT_NONE;
        ill1   <= 1'b0;
        imm2   <= '0;
        fmt2   <= FMT_NONE;
        ill2   <= 1'b0;
      end else if (bus.flush) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
      end else begin
        if (rdy2) begin
          v2 <= v1;
          if (v1) begin
            imm2 <= build_imm(instr1, fmt1);
            fmt2 <= fmt1;
            ill2 <= ill1;
          end
        end
        if (rdy1) begin
          v1 <= bus.in_valid;
          if (bus.in_valid) begin
            instr1 <= bus.instr;
            fmt1   <= cls_fmt;
            ill1   <= cls_ill;
          end
        end
      end
    end

    assign bus.in_ready    = rdy1;
    assign bus.out_valid   = v2;
    assign bus.imm         = imm2;
    assign bus.imm_fmt     = fmt2;
    assign bus.imm_illegal = ill2;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed-vector bench driving four imm_gen_pipe configurations in lockstep
module tb_imm_gen_pipe;

  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  f32;
    logic [31:0] i32;
    logic        l32;
    logic [2:0]  f64;
    logic [63:0] i64;
    logic        l64;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = '0;

  // index k: 0 = (32,1)  1 = (64,1)  2 = (32,2)  3 = (64,2)
  logic        ov [4];
  logic        ir [4];
  logic        il [4];
  logic [2:0]  fm [4];
  logic [63:0] im [4];

  int checks = 0;
  int errors = 0;
  vec_t vecs [17];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) bus32 [2] ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 [2] ();

  for (genvar s = 0; s < 2; s++) begin : g_dut
    imm_gen_pipe #(.XLEN(32), .STAGES(s + 1)) u32 (.clk(clk), .reset(reset), .bus(bus32[s].slave));
    imm_gen_pipe #(.XLEN(64), .STAGES(s + 1)) u64 (.clk(clk), .reset(reset), .bus(bus64[s].slave));
    assign bus32[s].in_valid  = in_valid;
    assign bus32[s].instr     = instr;
    assign bus32[s].flush     = flush;
    assign bus32[s].out_ready = out_ready;
    assign bus64[s].in_valid  = in_valid;
    assign bus64[s].instr     = instr;
    assign bus64[s].flush     = flush;
    assign bus64[s].out_ready = out_ready;
    assign ov[2*s]   = bus32[s].out_valid;
    assign ir[2*s]   = bus32[s].in_ready;
    assign il[2*s]   = bus32[s].imm_illegal;
    assign fm[2*s]   = bus32[s].imm_fmt;
    assign im[2*s]   = {32'b0, bus32[s].imm};
    assign ov[2*s+1] = bus64[s].out_valid;
    assign ir[2*s+1] = bus64[s].in_ready;
    assign il[2*s+1] = bus64[s].imm_illegal;
    assign fm[2*s+1] = bus64[s].imm_fmt;
    assign im[2*s+1] = bus64[s].imm;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_dut(input int k, input int n, input vec_t v);
    logic        x64;
    logic [63:0] ei;
    x64 = (k % 2) == 1;
    ei  = x64 ? v.i64 : {32'b0, v.i32};
    chk($sformatf("v%0d_d%0d_valid", n, k), 64'(ov[k]), 64'd1);
    chk($sformatf("v%0d_d%0d_imm", n, k), im[k], ei);
    chk($sformatf("v%0d_d%0d_fmt", n, k), 64'(fm[k]), 64'(x64 ? v.f64 : v.f32));
    chk($sformatf("v%0d_d%0d_ill", n, k), 64'(il[k]), 64'(x64 ? v.l64 : v.l32));
  endtask

  // One instruction in; 1-stage outputs checked after one edge, 2-stage after two.
  task automatic run_vec(input int n);
    @(negedge clk);
    instr     = vecs[n].instr;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 2) check_dut(k, n, vecs[n]);
      else chk($sformatf("v%0d_d%0d_early", n, k), 64'(ov[k]), 64'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k >= 2) check_dut(k, n, vecs[n]);
      else chk($sformatf("v%0d_d%0d_drained", n, k), 64'(ov[k]), 64'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int sent;
    int got;
    vecs[0]  = '{32'hFFF00093, F_I,    32'hFFFFFFFF, 1'b0, F_I,    64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'h12345037, F_U,    32'h12345000, 1'b0, F_U,    64'h0000000012345000, 1'b0};
    vecs[2]  = '{32'h80000037, F_U,    32'h80000000, 1'b0, F_U,    64'hFFFFFFFF80000000, 1'b0};
    vecs[3]  = '{32'hFE000EE3, F_B,    32'hFFFFFFFC, 1'b0, F_B,    64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[4]  = '{32'h02009093, F_SH,   32'h00000000, 1'b1, F_SH,   64'h0000000000000020, 1'b0};
    vecs[5]  = '{32'h0000000B, F_NONE, 32'h00000000, 1'b1, F_NONE, 64'h0000000000000000, 1'b1};
    vecs[6]  = '{32'hFE20AC23, F_S,    32'hFFFFFFF8, 1'b0, F_S,    64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[7]  = '{32'hFFDFF06F, F_J,    32'hFFFFFFFC, 1'b0, F_J,    64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[8]  = '{32'hFE002EE3, F_B,    32'hFFFFFFFC, 1'b1, F_B,    64'hFFFFFFFFFFFFFFFC, 1'b1};
    vecs[9]  = '{32'h00009067, F_I,    32'h00000000, 1'b1, F_I,    64'h0000000000000000, 1'b1};
    vecs[10] = '{32'h4030D093, F_SH,   32'h00000003, 1'b0, F_SH,   64'h0000000000000003, 1'b0};
    vecs[11] = '{32'h40309093, F_SH,   32'h00000003, 1'b1, F_SH,   64'h0000000000000003, 1'b1};
    vecs[12] = '{32'hFFF0809B, F_NONE, 32'h00000000, 1'b1, F_I,    64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[13] = '{32'h0200909B, F_NONE, 32'h00000000, 1'b1, F_SH,   64'h0000000000000000, 1'b1};
    vecs[14] = '{32'h003100B3, F_NONE, 32'h00000000, 1'b0, F_NONE, 64'h0000000000000000, 1'b0};
    vecs[15] = '{32'h00001017, F_U,    32'h00001000, 1'b0, F_U,    64'h0000000000001000, 1'b0};
    vecs[16] = '{32'hFFF12083, F_I,    32'hFFFFFFFF, 1'b0, F_I,    64'hFFFFFFFFFFFFFFFF, 1'b0};

    apply_reset();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_d%0d_valid", k), 64'(ov[k]), 64'd0);
      chk($sformatf("rst_d%0d_imm", k), im[k], 64'd0);
      chk($sformatf("rst_d%0d_fmt", k), 64'(fm[k]), 64'(F_NONE));
      chk($sformatf("rst_d%0d_ill", k), 64'(il[k]), 64'd0);
      chk($sformatf("rst_d%0d_in_ready", k), 64'(ir[k]), 64'd1);
    end

    for (int n = 0; n < 17; n++) run_vec(n);

    // Flush with two entries in flight plus a new instr offered.
    apply_reset();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h00500093;
    @(negedge clk);
    instr = 32'h00600093;
    @(negedge clk);
    instr = 32'h00700093;
    flush = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) chk($sformatf("flush_c%0d_d%0d_valid", c, k), 64'(ov[k]), 64'd0);
      @(negedge clk);
    end

    // An instr accepted in the flush cycle itself is dropped.
    in_valid = 1'b1;
    flush    = 1'b1;
    instr    = 32'h00800093;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) chk($sformatf("flushin_c%0d_d%0d_valid", c, k), 64'(ov[k]), 64'd0);
      @(negedge clk);
    end
    run_vec(3);

    // Backpressure on the 2-stage RV32 instance.
    apply_reset();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid  = (sent < 4);
      instr     = {12'(sent + 1), 20'h00093};
      #1;
      if (cyc == 2 || cyc == 3) begin
        chk($sformatf("bp_c%0d_in_ready", cyc), 64'(ir[2]), 64'd0);
        chk($sformatf("bp_c%0d_hold_valid", cyc), 64'(ov[2]), 64'd1);
        chk($sformatf("bp_c%0d_hold_imm", cyc), im[2], 64'd1);
      end
      if (ov[2] && out_ready) begin
        chk($sformatf("bp_out%0d_imm", got), im[2], 64'(got + 1));
        got++;
      end
      if (in_valid && ir[2]) sent++;
    end
    chk("bp_count", 64'(got), 64'd4);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_dup", 64'(ov[2]), 64'd0);

    // Async reset mid-stream, checked between clock edges.
    @(negedge clk);
    instr     = 32'h12345037;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ar_pre_valid", 64'(ov[2]), 64'd1);
    chk("ar_pre_imm", im[2], 64'h12345000);
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ar_d%0d_valid", k), 64'(ov[k]), 64'd0);
      chk($sformatf("ar_d%0d_imm", k), im[k], 64'd0);
      chk($sformatf("ar_d%0d_fmt", k), 64'(fm[k]), 64'(F_NONE));
    end
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
